viterbi_traceback_unit: RTL and testbench
=========================================

Name: viterbi_traceback_unit

Overview:
- Parametrised survivor-path traceback unit for the SPMU of the Viterbi decoder. It generalises the fixed 4-state traceback FSM to any constraint length K.
- Buffers per-step ACS decision vectors in a circular survivor memory and performs block traceback of depth TB_DEPTH.
- Reverses the decoded bits through an internal LIFO so that DEC_LEN bits per block leave in chronological order.
- Sits between the ACS/PMU array (upstream) and the output bit sink (downstream).

Parameters:
- K, 3, constraint length; M = K-1 state bits; NS = 2^M states; legal range 3..9.
- TB_DEPTH, 16, traceback steps discarded before decoding; must be >= 1.
- DEC_LEN, 8, bits decoded and emitted per traceback; must be >= 1.
- TB_MODE, 0, start-state selection: 0 = use i_best_state; 1 = always start from state 0.

Ports:
- i_clk, input, 1, clock.
- i_rst_n, input, 1, reset, asynchronous, active-low.
- i_valid, input, 1, decision vector valid.
- i_dec, input, NS, decision bits; bit s = LSB of the surviving predecessor of state s.
- i_best_state, input, M, best-metric state at this step; used only in TB_MODE 0.
- o_in_ready, output, 1, input accepted when i_valid & o_in_ready.
- o_valid, output, 1, decoded bit valid.
- o_data, output, 1, decoded bit.
- o_last, output, 1, last bit of the DEC_LEN block.
- o_busy, output, 1, high in TRACE or OUT.

Behaviour:
- State convention:
  - s = {u[t-1] .. u[t-M]}, with the newest input bit at the MSB.
  - Predecessor of s = {s[M-2:0], i_dec[s]}.
  - Decoded bit at s = s[M-1].
- Survivor memory: MEM = TB_DEPTH + DEC_LEN entries of NS bits, with write pointer wptr.
  - Each accepted vector is written to mem[wptr].
  - wptr wraps from MEM-1 to 0.
- Reset: FSM = FILL, wptr = 0, fill counter = 0, need = MEM, LIFO empty.
  - Outputs at reset: o_in_ready = 1, o_valid = 0, o_data = 0, o_last = 0, o_busy = 0.
- FILL:
  - o_in_ready = 1; each handshake increments the fill counter.
  - On the handshake that makes the counter equal need:
    - latch newest pointer = wptr;
    - latch start state = i_best_state (TB_MODE 0) or 0 (TB_MODE 1);
    - clear the counter.
  - Next cycle: go to TRACE.
- TRACE (exactly MEM cycles, o_in_ready = 0, o_busy = 1):
  - Cycle j reads mem[(newest - j) mod MEM] combinationally; s <= {s[M-2:0], dec[s]}.
  - For j < TB_DEPTH: no output.
  - For j >= TB_DEPTH: push s[M-1] (value before update) into the DEC_LEN-deep LIFO.
  - After cycle MEM-1: go to OUT.
- OUT (exactly DEC_LEN cycles, o_in_ready = 0):
  - Pop the LIFO with o_valid = 1, so the oldest decoded bit comes out first.
  - o_last = 1 on the final pop.
  - Then go to FILL with need = DEC_LEN. New writes overwrite only the DEC_LEN oldest, already-decoded entries.
- No downstream backpressure; the sink must accept every o_valid cycle.
- Latency from the completing handshake to the first o_valid: MEM + 1 cycles.
- Steady-state throughput: DEC_LEN bits per (DEC_LEN + MEM + DEC_LEN) cycles at full input rate.
- First block: requires MEM accepted vectors; later blocks require DEC_LEN.
- i_valid while o_in_ready = 0: ignored. The vector is not written and does not count.
- i_best_state is sampled only on the completing handshake; it is ignored otherwise.
- Reset asserted mid-TRACE or mid-OUT:
  - immediate return to reset values;
  - the LIFO is discarded with no partial block emitted;
  - the next block again requires MEM vectors.
- Pointer arithmetic is modulo MEM, so MEM need not be a power of 2.
- i_dec bits for unreachable states are don't-care.

Test Plan:
1. K=3, TB_DEPTH=4, DEC_LEN=4, TB_MODE=1, 8 all-zero vectors:
   - o_in_ready drops after vector 8;
   - o_valid rises 9 cycles later;
   - 4 bits 0,0,0,0 are emitted with o_last on the 4th.
2. K=3, TB_DEPTH=4, DEC_LEN=4, TB_MODE=0, vectors generated by the encoder model for u = 1,0,1,1,0,0,1,0, with i_best_state = true final state (2'b01) on the 8th:
   - output 1,0,1,1 in order.
   - Then supply 4 more vectors for u = 1,1,0,1 (best state 2'b10) → output 0,0,1,0, which exercises wptr wrap.
3. Same setup as scenario 2, with i_valid held high during TRACE/OUT carrying corrupt vectors:
   - none are accepted;
   - the fill counter is unchanged;
   - output is identical to scenario 2.
4. i_rst_n pulsed low on TRACE cycle 3:
   - all outputs return to 0 and o_in_ready to 1 asynchronously;
   - no o_valid follows;
   - the next block needs 8 vectors.
5. K=5 (NS=16), TB_DEPTH=20, DEC_LEN=10, TB_MODE=0, random encoded stream of 200 bits with 1-in-3 idle i_valid gaps:
   - decoded stream matches the source bits exactly, delayed in blocks of 10;
   - o_last fires every 10th bit.
6. Wrong i_best_state (state 0 instead of the correct state) with TB_DEPTH=20, error-free stream:
   - the traceback converges;
   - all DEC_LEN output bits are still correct.

Source files
------------

// File: rtl/viterbi_traceback_unit.sv
// Survivor-path traceback for a Viterbi decoder of constraint length K. Buffers ACS decisions,
// performs block traceback and emits DEC_LEN decoded bits per block in chronological order.
module viterbi_traceback_unit #(
  parameter int unsigned K        = 3,
  parameter int unsigned TB_DEPTH = 16,
  parameter int unsigned DEC_LEN  = 8,
  parameter int unsigned TB_MODE  = 0
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  input  logic [(1 << (K - 1)) - 1:0] i_dec,
  input  logic [K-2:0]                i_best_state,
  output logic                        o_in_ready,
  output logic                        o_valid,
  output logic                        o_data,
  output logic                        o_last,
  output logic                        o_busy
);

  localparam int unsigned M   = K - 1;
  localparam int unsigned NS  = 1 << M;
  localparam int unsigned MEM = TB_DEPTH + DEC_LEN;
  localparam int unsigned PW  = $clog2(MEM);
  localparam int unsigned CW  = $clog2(MEM + 1);
  localparam int unsigned OW  = $clog2(DEC_LEN + 1);

  typedef enum logic [1:0] {StFill, StTrace, StOut} state_e;

  state_e st_q, st_d;

  logic [NS-1:0]      mem_q [MEM];
  logic [PW-1:0]      wptr_q, rd_ptr_q;
  logic [CW-1:0]      fill_cnt_q, trace_cnt_q, need;
  logic [OW-1:0]      out_cnt_q;
  logic [M-1:0]       tb_state_q;
  logic [DEC_LEN-1:0] lifo_q;
  logic               first_q;
  logic               accept, fill_done, trace_end, out_end;
  logic [NS-1:0]      rd_vec;

  assign need      = first_q ? CW'(MEM) : CW'(DEC_LEN);
  assign accept    = (st_q == StFill) && i_valid;
  assign fill_done = accept && ((fill_cnt_q + 1'b1) == need);
  assign trace_end = (st_q == StTrace) && (trace_cnt_q == CW'(MEM - 1));
  assign out_end   = (st_q == StOut) && (out_cnt_q == OW'(DEC_LEN - 1));
  assign rd_vec    = mem_q[rd_ptr_q];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q <= StFill;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StFill:  if (fill_done) st_d = StTrace;
      StTrace: if (trace_end) st_d = StOut;
      StOut:   if (out_end) st_d = StFill;
      default: st_d = StFill;
    endcase
  end

  always_comb begin
    o_in_ready = (st_q == StFill);
    o_busy     = (st_q != StFill);
    o_valid    = (st_q == StOut);
    o_data     = o_valid & lifo_q[0];
    o_last     = out_end;
  end

  // Survivor memory holds no reset: entries are always written before traceback reads them.
  always_ff @(posedge i_clk) begin
    if (accept) mem_q[wptr_q] <= i_dec;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q      <= '0;
      rd_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      trace_cnt_q <= '0;
      out_cnt_q   <= '0;
      tb_state_q  <= '0;
      lifo_q      <= '0;
      first_q     <= 1'b1;
    end else begin
      if (accept) begin
        wptr_q     <= (wptr_q == PW'(MEM - 1)) ? '0 : wptr_q + 1'b1;
        fill_cnt_q <= fill_done ? '0 : fill_cnt_q + 1'b1;
      end
      if (fill_done) begin
        rd_ptr_q    <= wptr_q;
        tb_state_q  <= (TB_MODE == 1) ? '0 : i_best_state;
        trace_cnt_q <= '0;
      end
      if (st_q == StTrace) begin
        rd_ptr_q    <= (rd_ptr_q == '0) ? PW'(MEM - 1) : rd_ptr_q - 1'b1;
        tb_state_q  <= {tb_state_q[M-2:0], rd_vec[tb_state_q]};
        trace_cnt_q <= trace_cnt_q + 1'b1;
        out_cnt_q   <= '0;
        // Newest-in-time bits are pushed first, so the shift LIFO pops the oldest first.
        if (trace_cnt_q >= CW'(TB_DEPTH)) lifo_q <= DEC_LEN'({lifo_q, tb_state_q[M-1]});
      end
      if (st_q == StOut) begin
        lifo_q    <= lifo_q >> 1;
        out_cnt_q <= out_cnt_q + 1'b1;
        if (out_end) first_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_viterbi_traceback_unit.sv
// Directed bench for viterbi_traceback_unit: three instances cover TB_MODE 1/0 at K=3 and a
// K=5 configuration driven by an in-bench encoder model.
module tb_viterbi_traceback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_a, valid_b, valid_c;
  logic [15:0] dec_w;
  logic [3:0]  best_w;
  logic        rdy_a, ov_a, od_a, ol_a, busy_a;
  logic        rdy_b, ov_b, od_b, ol_b, busy_b;
  logic        rdy_c, ov_c, od_c, ol_c, busy_c;

  int n_checks = 0;
  int n_pass   = 0;

  bit qd_a[$], ql_a[$], qd_b[$], ql_b[$], qd_c[$], ql_c[$];
  bit src[$];

  logic [1:0]  st3;
  logic [3:0]  st5;
  logic [0:11] u2 = 12'b1011_0010_1101;
  logic [0:7]  e2 = 8'b1011_0010;

  always #5 clk = ~clk;

  viterbi_traceback_unit #(.K(3), .TB_DEPTH(4), .DEC_LEN(4), .TB_MODE(1)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_a), .i_dec(dec_w[3:0]),
    .i_best_state(best_w[1:0]), .o_in_ready(rdy_a), .o_valid(ov_a), .o_data(od_a),
    .o_last(ol_a), .o_busy(busy_a)
  );

  viterbi_traceback_unit #(.K(3), .TB_DEPTH(4), .DEC_LEN(4), .TB_MODE(0)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_b), .i_dec(dec_w[3:0]),
    .i_best_state(best_w[1:0]), .o_in_ready(rdy_b), .o_valid(ov_b), .o_data(od_b),
    .o_last(ol_b), .o_busy(busy_b)
  );

  viterbi_traceback_unit #(.K(5), .TB_DEPTH(20), .DEC_LEN(10), .TB_MODE(0)) u_dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_c), .i_dec(dec_w),
    .i_best_state(best_w), .o_in_ready(rdy_c), .o_valid(ov_c), .o_data(od_c),
    .o_last(ol_c), .o_busy(busy_c)
  );

  always @(negedge clk) begin
    if (ov_a) begin qd_a.push_back(od_a); ql_a.push_back(ol_a); end
    if (ov_b) begin qd_b.push_back(od_b); ql_b.push_back(ol_b); end
    if (ov_c) begin qd_c.push_back(od_c); ql_c.push_back(ol_c); end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? rdy_a : (sel == 1) ? rdy_b : rdy_c;
  endfunction

  function automatic int qsize(input int sel);
    return (sel == 0) ? qd_a.size() : (sel == 1) ? qd_b.size() : qd_c.size();
  endfunction

  task automatic set_valid(input int sel, input logic v);
    case (sel)
      0:       valid_a = v;
      1:       valid_b = v;
      default: valid_c = v;
    endcase
  endtask

  // Waits for o_in_ready, then presents one vector; while waiting, optionally drives junk.
  task automatic push(input int sel, input logic [15:0] d, input logic [3:0] bs,
                      input bit junk, output int waits);
    waits = 0;
    forever begin
      @(negedge clk);
      if (rdy(sel)) begin
        set_valid(sel, 1'b1);
        dec_w  = d;
        best_w = bs;
        break;
      end
      set_valid(sel, junk);
      dec_w  = 16'($urandom);
      best_w = 4'($urandom);
      waits++;
      if (waits > 200) begin
        check("push_wait", 32'(rdy(sel)), 1);
        break;
      end
    end
  endtask

  task automatic idle(input int sel);
    @(negedge clk);
    set_valid(sel, 1'b0);
  endtask

  task automatic wait_out(input int sel, input int n);
    int cyc = 0;
    while (qsize(sel) < n && cyc < 600) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("out_count", qsize(sel), n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    valid_c = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    qd_a.delete(); ql_a.delete(); qd_b.delete(); ql_b.delete();
    qd_c.delete(); ql_c.delete(); src.delete();
  endtask

  // Encoder model: decision bit at the true state is the LSB of its predecessor; other states
  // carry the opposite value (K=3) or random/broadcast bits (K=5).
  task automatic gen3(input bit u, output logic [15:0] d, output logic [3:0] bs);
    logic b;
    logic [3:0] v;
    b   = st3[0];
    st3 = {u, st3[1]};
    v   = {4{~b}};
    v[st3] = b;
    d  = {12'h000, v};
    bs = {2'b00, st3};
  endtask

  task automatic gen5(input bit u, input bit rnd, output logic [15:0] d, output logic [3:0] bs);
    logic b;
    b   = st5[0];
    st5 = {u, st5[3:1]};
    d   = rnd ? 16'($urandom) : {16{b}};
    d[st5] = b;
    bs = st5;
  endtask

  task automatic run_s2(input bit junk, input string tg);
    int w, cyc;
    logic [15:0] d;
    logic [3:0]  bs;
    st3 = 2'b00;
    for (int i = 0; i < 12; i++) begin
      gen3(u2[i], d, bs);
      push(1, d, bs, junk, w);
      if (i > 8) check({tg, "_early_block"}, w, 0);
    end
    @(negedge clk);
    check({tg, "_ready_drop"}, 32'(rdy_b), 0);
    cyc = 0;
    while (!rdy_b && cyc < 100) begin
      set_valid(1, junk);
      dec_w = 16'($urandom);
      @(negedge clk);
      cyc++;
    end
    valid_b = 1'b0;
    wait_out(1, 8);
    for (int i = 0; i < 8 && i < qd_b.size(); i++) begin
      check({tg, "_bit"}, 32'(qd_b[i]), 32'(e2[i]));
      check({tg, "_last"}, 32'(ql_b[i]), 32'((i % 4) == 3));
    end
  endtask

  initial begin
    int k, w;
    logic [15:0] d;
    logic [3:0]  bs;
    bit u;

    rst_n   = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    valid_c = 1'b0;
    dec_w   = '0;
    best_w  = '0;
    #1;
    check("rst_ready", 32'(rdy_a), 1);
    check("rst_valid", 32'(ov_a), 0);
    check("rst_data", 32'(od_a), 0);
    check("rst_last", 32'(ol_a), 0);
    check("rst_busy", 32'(busy_c), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: all-zero vectors, start state forced to 0.
    for (int i = 0; i < 8; i++) push(0, 16'h0000, 4'h0, 1'b0, w);
    @(negedge clk);
    valid_a = 1'b0;
    check("s1_ready_drop", 32'(rdy_a), 0);
    check("s1_busy", 32'(busy_a), 1);
    k = 1;
    while (!ov_a && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("s1_latency", k, 9);
    wait_out(0, 4);
    for (int i = 0; i < 4 && i < qd_a.size(); i++) begin
      check("s1_bit", 32'(qd_a[i]), 0);
      check("s1_last", 32'(ql_a[i]), 32'(i == 3));
    end

    // Scenarios 2 and 3: encoded stream with wrap; then with junk during TRACE/OUT.
    do_reset();
    run_s2(1'b0, "s2");
    do_reset();
    run_s2(1'b1, "s3");

    // Scenario 4: reset on TRACE cycle 3.
    do_reset();
    st3 = 2'b00;
    for (int i = 0; i < 8; i++) begin
      gen3(u2[i], d, bs);
      push(1, d, bs, 1'b0, w);
    end
    idle(1);
    repeat (3) @(negedge clk);
    check("s4_busy_pre", 32'(busy_b), 1);
    rst_n = 1'b0;
    #1;
    check("s4_rst_valid", 32'(ov_b), 0);
    check("s4_rst_busy", 32'(busy_b), 0);
    check("s4_rst_ready", 32'(rdy_b), 1);
    check("s4_rst_data", 32'(od_b), 0);
    check("s4_rst_last", 32'(ol_b), 0);
    #2;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("s4_no_out", qd_b.size(), 0);
    st3 = 2'b00;
    for (int i = 0; i < 7; i++) begin
      gen3(u2[i], d, bs);
      push(1, d, bs, 1'b0, w);
    end
    idle(1);
    repeat (12) @(negedge clk);
    #1;
    check("s4_still_ready", 32'(rdy_b), 1);
    check("s4_no_out_7", qd_b.size(), 0);
    gen3(u2[7], d, bs);
    push(1, d, bs, 1'b0, w);
    idle(1);
    wait_out(1, 4);
    for (int i = 0; i < 4 && i < qd_b.size(); i++) check("s4_bit", 32'(qd_b[i]), 32'(e2[i]));

    // Scenario 5: K=5 random stream with idle gaps.
    do_reset();
    st5 = 4'h0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) idle(2);
      u = 1'($urandom_range(0, 1));
      src.push_back(u);
      gen5(u, 1'b1, d, bs);
      push(2, d, bs, 1'b0, w);
    end
    idle(2);
    wait_out(2, 180);
    for (int i = 0; i < 180 && i < qd_c.size(); i++) begin
      check("s5_bit", 32'(qd_c[i]), 32'(src[i]));
      check("s5_last", 32'(ql_c[i]), 32'((i % 10) == 9));
    end

    // Scenario 6: wrong start state (0) with a nonzero true final state.
    do_reset();
    st5 = 4'h0;
    for (int i = 0; i < 30; i++) begin
      u = (i == 29) ? 1'b1 : 1'($urandom_range(0, 1));
      src.push_back(u);
      gen5(u, 1'b0, d, bs);
      push(2, d, 4'h0, 1'b0, w);
    end
    idle(2);
    wait_out(2, 10);
    for (int i = 0; i < 10 && i < qd_c.size(); i++) check("s6_bit", 32'(qd_c[i]), 32'(src[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d of %0d checks passing",
             n_pass, n_checks);
    $fatal(1);
  end

endmodule
